sim_host_mmio: RTL and testbench
================================

# sim_host_mmio

Memory-mapped simulation host device on the CPU data-memory request path, beside the data cache. It latches the program exit status and runs a cycle-bounded watchdog. It buffers console bytes in a parametrised FIFO drained over a valid/ready port, and exposes a 64-bit cycle counter and a status word. It is the parametrised successor of the hard-wired exit-address check: it adds console output, timeout, error responses and configurable base and depth.

## Interface
- xlen, 32: data/address width (32 or 64).
- base_addr, 32'hFFFF_FFF0: 16-byte-aligned base of the 4-word register window.
- fifo_depth, 16: console FIFO entries; power of two, ≥2.
- timeout_cycles, 0: watchdog limit in cycles; 0 disables.
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- r_v  in  1  read request.
- w_v  in  1  write request.
- adr  in  xlen  byte address.
- data  in  xlen  write data.
- strobe  in  xlen/8  byte enables.
- hit  out  1  combinational: adr is inside the window and (r_v|w_v); used to steer the response mux away from dmem.
- resp  out  xlen  read data.
- resp_valid  out  1  response strobe.
- resp_error  out  1  response error.
- cons_data  out  8  console byte at FIFO head.
- cons_valid  out  1  FIFO non-empty.
- cons_ready  in  1  consumer accepts byte.
- exit_valid  out  1  sticky: program finished.
- exit_status  out  xlen  status value.
- exit_timeout  out  1  sticky: exit was caused by the watchdog.

## Operation
- Window: in-window when adr[xlen-1:4]==base_addr[xlen-1:4]. Word offset is adr[3:2].
  - 0x0 EXIT (W): write data to exit_status and set exit_valid. Reads return 0.
  - 0x4 CONSOLE (W): push data[7:0] when strobe[0]=1. Reads return 0.
  - 0x8 CYCLE (R): low xlen bits of the 64-bit cycle counter. Writes are ignored.
  - 0xC STATUS (R): bit0 exit_valid, bit1 overflow (sticky), bits[15:8] FIFO level. Writes clear overflow.
- Error cases: adr[1:0]≠0, or r_v&w_v together. The response has resp_error=1, resp=0 and there is no side effect.
- Exit is first-wins. Once exit_valid=1, further EXIT writes and watchdog expiry are ignored.
- Watchdog: enabled when timeout_cycles≠0 and exit_valid=0. When the cycle counter reaches timeout_cycles, set exit_valid=1, exit_timeout=1 and exit_status={xlen{1'b1}}.
- Console FIFO:
  - Push when full: the byte is dropped, overflow is set and the response is still OK.
  - Pop on cons_valid&cons_ready.
  - Push and pop in the same cycle when full: both happen and the level is unchanged.
  - Push when empty makes the byte visible on the next cycle. There is no bypass.
- The cycle counter increments every cycle from 0 after reset. It wraps at 2^64.
- Out-of-window requests: hit=0 and no response is driven.

## Timing
- One-cycle latency. An in-window request in cycle N gives resp_valid=1 and resp/resp_error in cycle N+1, for one cycle. No backpressure: a new request is accepted every cycle.
- A write's register effect is visible to a read issued in the next cycle.
- The CYCLE read returns the counter value sampled in cycle N.
- Outputs after reset: resp=0, resp_valid=0, resp_error=0, cons_valid=0, cons_data=0, exit_valid=0, exit_status=0, exit_timeout=0. Counter, overflow and FIFO are cleared.
- Reset mid-operation: all state clears on the next edge. An in-flight response is dropped with resp_valid=0 and FIFO contents are lost.
- exit_valid rises the cycle after the EXIT write or watchdog match.

## Test plan
- Write 0x2A to base+0x0 -> resp_valid=1 next cycle, resp_error=0. exit_valid=1, exit_status=0x2A. A second write of 0x5 leaves status at 0x2A.
- Push "HI" (0x48, 0x49) with cons_ready=0, then raise cons_ready -> STATUS level=2; bytes 0x48 then 0x49 pop on consecutive cycles; cons_valid=0 afterwards.
- Push 17 bytes into depth 16 with cons_ready=0 -> STATUS reads level=16 and overflow=1. Write STATUS -> overflow=0. The 17th byte is never output.
- timeout_cycles=100 with no EXIT write -> exit_valid=1, exit_timeout=1, exit_status=0xFFFFFFFF at the 101st cycle after reset release.
- Read at base+0x2, and r_v&w_v together at base+0x0 -> resp_error=1, resp=0, exit_valid stays 0.
- Full FIFO with simultaneous push and pop -> level stays 16, no overflow. Assert rst mid-stream -> all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/sim_host_mmio.sv
// sim_host_mmio
//
// Memory-mapped simulation host device that sits beside the data cache on the
// CPU data-memory request path. It provides a 4-word register window:
//   +0x0 EXIT    (W)  latch program exit status, first write wins
//   +0x4 CONSOLE (W)  push data[7:0] into the console FIFO when strobe[0]=1
//   +0x8 CYCLE   (R)  low xlen bits of the free-running 64-bit cycle counter
//   +0xC STATUS  (R)  bit0 exit_valid, bit1 overflow, bits[15:8] FIFO level;
//                     any write clears overflow
// A watchdog forces an exit with all-ones status once the cycle counter
// reaches timeout_cycles (0 disables it).
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   r_v, w_v          read / write request strobes
//   adr, data, strobe byte address, write data, byte enables
//   hit               combinational in-window indication for the response mux
//   resp, resp_valid, resp_error
//                     registered one-cycle-latency response
//   cons_data, cons_valid, cons_ready
//                     console FIFO head, drained over valid/ready
//   exit_valid, exit_status, exit_timeout
//                     sticky program-exit information
module sim_host_mmio #(
  parameter int              xlen           = 32,
  parameter logic [xlen-1:0] base_addr      = xlen'(32'hFFFF_FFF0),
  parameter int              fifo_depth     = 16,
  parameter logic [63:0]     timeout_cycles = 64'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_v,
  input  logic              w_v,
  input  logic [xlen-1:0]   adr,
  input  logic [xlen-1:0]   data,
  input  logic [xlen/8-1:0] strobe,
  output logic              hit,
  output logic [xlen-1:0]   resp,
  output logic              resp_valid,
  output logic              resp_error,
  output logic [7:0]        cons_data,
  output logic              cons_valid,
  input  logic              cons_ready,
  output logic              exit_valid,
  output logic [xlen-1:0]   exit_status,
  output logic              exit_timeout
);

  localparam int aw = $clog2(fifo_depth);
  localparam int lw = aw + 1;

  logic              req_err;
  logic              wr_ok;
  logic              rd_ok;
  logic [1:0]        offset;
  logic [63:0]       cycle_cnt;
  logic              overflow;
  logic [lw-1:0]     wr_ptr;
  logic [lw-1:0]     rd_ptr;
  logic [lw-1:0]     level;
  logic [7:0]        fifo_mem [fifo_depth];
  logic              full;
  logic              pop;
  logic              push_req;
  logic              push;
  logic              wd_fire;
  logic [xlen-1:0]   status_word;
  logic [xlen-1:0]   rd_data;
  logic              unused_strobe;

  // Request decode. Misaligned addresses and simultaneous read+write are
  // answered with an error and must not touch any register.
  assign hit     = (adr[xlen-1:4] == base_addr[xlen-1:4]) && (r_v || w_v);
  assign req_err = (adr[1:0] != 2'b00) || (r_v && w_v);
  assign offset  = adr[3:2];
  assign wr_ok   = hit && !req_err && w_v;
  assign rd_ok   = hit && !req_err && r_v;

  // Only byte lane 0 gates the console push; the other lanes carry no meaning.
  assign unused_strobe = ^strobe[xlen/8-1:1];

  // Pointers are one bit wider than the index so full and empty differ.
  // A push into a full FIFO still succeeds when the head leaves in the same
  // cycle; otherwise it is dropped and flagged as overflow.
  assign level      = wr_ptr - rd_ptr;
  assign full       = (level == lw'(fifo_depth));
  assign cons_valid = (level != '0);
  assign pop        = cons_valid && cons_ready;
  assign push_req   = wr_ok && (offset == 2'd1) && strobe[0];
  assign push       = push_req && (!full || pop);
  assign cons_data  = cons_valid ? fifo_mem[rd_ptr[aw-1:0]] : 8'h00;

  // The watchdog stops watching once any exit has been recorded.
  assign wd_fire = (timeout_cycles != 64'd0) && !exit_valid &&
                   (cycle_cnt == timeout_cycles);

  // Read data mux; EXIT and CONSOLE read as zero, errors and writes return zero.
  always_comb begin
    status_word       = '0;
    status_word[0]    = exit_valid;
    status_word[1]    = overflow;
    status_word[15:8] = 8'(level);
    rd_data           = '0;
    if (rd_ok) begin
      case (offset)
        2'd2:    rd_data = cycle_cnt[xlen-1:0];
        2'd3:    rd_data = status_word;
        default: rd_data = '0;
      endcase
    end
  end

  // Console storage has no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[aw-1:0]] <= data[7:0];
    end
  end

  // Control state, exit latch and the registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt    <= '0;
      overflow     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      exit_valid   <= 1'b0;
      exit_status  <= '0;
      exit_timeout <= 1'b0;
      resp         <= '0;
      resp_valid   <= 1'b0;
      resp_error   <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;

      if (push) begin
        wr_ptr <= wr_ptr + lw'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + lw'(1);
      end

      if (wr_ok && (offset == 2'd3)) begin
        overflow <= 1'b0;
      end else if (push_req && !push) begin
        overflow <= 1'b1;
      end

      // A program EXIT write in the same cycle as the watchdog match wins.
      if (!exit_valid) begin
        if (wr_ok && (offset == 2'd0)) begin
          exit_valid  <= 1'b1;
          exit_status <= data;
        end else if (wd_fire) begin
          exit_valid   <= 1'b1;
          exit_timeout <= 1'b1;
          exit_status  <= '1;
        end
      end

      resp_valid <= hit;
      resp_error <= hit && req_err;
      resp       <= rd_data;
    end
  end

endmodule

// File: tb/tb_sim_host_mmio.sv
// tb_sim_host_mmio
//
// Self-checking bench for sim_host_mmio. One instance (watchdog disabled)
// exercises the register window, console FIFO and reset; a second instance
// with timeout_cycles=100 and idle inputs exercises the watchdog.
// Responses are checked through a scoreboard queue filled when a request is
// driven and drained one cycle later by a response monitor.
module tb_sim_host_mmio;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;

  logic        clk;
  logic        rst;
  logic        r_v;
  logic        w_v;
  logic [31:0] adr;
  logic [31:0] data;
  logic [3:0]  strobe;
  logic        hit;
  logic [31:0] resp;
  logic        resp_valid;
  logic        resp_error;
  logic [7:0]  cons_data;
  logic        cons_valid;
  logic        cons_ready;
  logic        exit_valid;
  logic [31:0] exit_status;
  logic        exit_timeout;

  logic        wd_rst;
  logic        wd_idle;
  logic [31:0] wd_zero;
  logic [3:0]  wd_strb;
  logic        wd_hit;
  logic [31:0] wd_resp;
  logic        wd_resp_valid;
  logic        wd_resp_error;
  logic [7:0]  wd_cons_data;
  logic        wd_cons_valid;
  logic        wd_exit_valid;
  logic [31:0] wd_exit_status;
  logic        wd_exit_timeout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] resp;
    logic        err;
  } exp_t;

  typedef struct {
    logic        rv;
    logic        wv;
    logic [31:0] adr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        exp_hit;
    logic [31:0] exp_resp;
    logic        exp_err;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic        mon_rst;
  logic [63:0] tb_cyc;
  vec_t        vecs[14];
  logic [7:0]  exp_bytes[$];

  sim_host_mmio #(
    .xlen(32), .base_addr(BASE), .fifo_depth(16), .timeout_cycles(64'd0)
  ) dut (
    .clk(clk), .rst(rst), .r_v(r_v), .w_v(w_v), .adr(adr), .data(data),
    .strobe(strobe), .hit(hit), .resp(resp), .resp_valid(resp_valid),
    .resp_error(resp_error), .cons_data(cons_data), .cons_valid(cons_valid),
    .cons_ready(cons_ready), .exit_valid(exit_valid),
    .exit_status(exit_status), .exit_timeout(exit_timeout)
  );

  sim_host_mmio #(
    .xlen(32), .base_addr(BASE), .fifo_depth(16), .timeout_cycles(64'd100)
  ) u_wd (
    .clk(clk), .rst(wd_rst), .r_v(wd_idle), .w_v(wd_idle), .adr(wd_zero),
    .data(wd_zero), .strobe(wd_strb), .hit(wd_hit), .resp(wd_resp),
    .resp_valid(wd_resp_valid), .resp_error(wd_resp_error),
    .cons_data(wd_cons_data), .cons_valid(wd_cons_valid),
    .cons_ready(wd_idle), .exit_valid(wd_exit_valid),
    .exit_status(wd_exit_status), .exit_timeout(wd_exit_timeout)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] time bound expired");
  end

  // Reference cycle counter: zero after a reset edge, +1 on every other edge.
  always @(posedge clk) begin
    if (rst) tb_cyc <= 64'd0;
    else     tb_cyc <= tb_cyc + 64'd1;
  end

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Response monitor: every edge either retires exactly one expected
  // response or must show no response at all. A reset edge drops anything
  // in flight.
  always @(posedge clk) begin
    mon_rst = rst;
    #1;
    if (mon_rst) begin
      exp_q.delete();
      check_output("resp_valid_reset", 64'(resp_valid), 64'd0);
    end else if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_output("resp_valid", 64'(resp_valid), 64'd1);
      check_output("resp", 64'(resp), 64'(mon_e.resp));
      check_output("resp_error", 64'(resp_error), 64'(mon_e.err));
    end else begin
      check_output("resp_valid_idle", 64'(resp_valid), 64'd0);
    end
  end

  // Drive one request for one cycle and record the expected response.
  task automatic apply_stimulus(input string name, input logic rv,
                                input logic wv, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] s,
                                input logic exp_hit,
                                input logic [31:0] exp_resp,
                                input logic exp_err, input bit exp_cycle);
    logic [31:0] er;
    @(negedge clk);
    r_v    = rv;
    w_v    = wv;
    adr    = a;
    data   = d;
    strobe = s;
    er     = exp_cycle ? tb_cyc[31:0] : exp_resp;
    #1;
    check_output({name, "_hit"}, 64'(hit), 64'(exp_hit));
    if (exp_hit) exp_q.push_back('{er, exp_err});
  endtask

  task automatic idle();
    @(negedge clk);
    r_v    = 1'b0;
    w_v    = 1'b0;
    adr    = 32'h0;
    data   = 32'h0;
    strobe = 4'h0;
  endtask

  // Pop every byte in exp_bytes on consecutive cycles and confirm empty after.
  task automatic drain_console(input string name);
    for (int i = 0; i < exp_bytes.size(); i++) begin
      check_output({name, "_valid"}, 64'(cons_valid), 64'd1);
      check_output({name, "_byte"}, 64'(cons_data), 64'(exp_bytes[i]));
      cons_ready = 1'b1;
      @(negedge clk);
    end
    cons_ready = 1'b0;
    check_output({name, "_empty"}, 64'(cons_valid), 64'd0);
    check_output({name, "_empty_data"}, 64'(cons_data), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    wd_rst     = 1'b1;
    r_v        = 1'b0;
    w_v        = 1'b0;
    adr        = 32'h0;
    data       = 32'h0;
    strobe     = 4'h0;
    cons_ready = 1'b0;
    wd_idle    = 1'b0;
    wd_zero    = 32'h0;
    wd_strb    = 4'h0;

    //              rv    wv    adr            data          strb  hit   resp          err
    vecs[0]  = '{1'b1, 1'b0, BASE + 32'h0, 32'h0,        4'h0, 1'b1, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, BASE + 32'hC, 32'h0,        4'h0, 1'b1, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 1'b0, BASE + 32'h2, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1};
    vecs[3]  = '{1'b1, 1'b1, BASE + 32'h0, 32'h77,       4'hF, 1'b1, 32'h0,        1'b1};
    vecs[4]  = '{1'b0, 1'b1, BASE + 32'h1, 32'h99,       4'hF, 1'b1, 32'h0,        1'b1};
    vecs[5]  = '{1'b1, 1'b0, BASE + 32'hC, 32'h0,        4'h0, 1'b1, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,       4'h0, 1'b0, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 1'b1, BASE + 32'h0, 32'h2A,       4'hF, 1'b1, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 1'b0, BASE + 32'hC, 32'h0,        4'h0, 1'b1, 32'h1,        1'b0};
    vecs[9]  = '{1'b0, 1'b1, BASE + 32'h0, 32'h5,        4'hF, 1'b1, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 1'b1, BASE + 32'h8, 32'h1234,     4'hF, 1'b1, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 1'b0, BASE + 32'h4, 32'h0,        4'h0, 1'b1, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 1'b0, BASE + 32'hC, 32'h0,        4'h0, 1'b1, 32'h1,        1'b0};
    vecs[13] = '{1'b0, 1'b1, 32'hFFFF_FFE0, 32'h7,       4'hF, 1'b0, 32'h0,        1'b0};

    repeat (3) @(negedge clk);
    check_output("rst_resp", 64'(resp), 64'd0);
    check_output("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_output("rst_resp_error", 64'(resp_error), 64'd0);
    check_output("rst_cons_valid", 64'(cons_valid), 64'd0);
    check_output("rst_cons_data", 64'(cons_data), 64'd0);
    check_output("rst_exit_valid", 64'(exit_valid), 64'd0);
    check_output("rst_exit_status", 64'(exit_status), 64'd0);
    check_output("rst_exit_timeout", 64'(exit_timeout), 64'd0);
    rst = 1'b0;

    // Register window, error cases and first-wins exit, back to back.
    for (int i = 0; i < 14; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].rv, vecs[i].wv,
                     vecs[i].adr, vecs[i].data, vecs[i].strb, vecs[i].exp_hit,
                     vecs[i].exp_resp, vecs[i].exp_err, 1'b0);
    end
    idle();
    check_output("exit_valid", 64'(exit_valid), 64'd1);
    check_output("exit_status_first_wins", 64'(exit_status), 64'h2A);
    check_output("exit_timeout_off", 64'(exit_timeout), 64'd0);

    // Two consecutive CYCLE reads return the counter of their own cycle.
    apply_stimulus("cycle_a", 1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'h0, 1'b1,
                   32'h0, 1'b0, 1'b1);
    apply_stimulus("cycle_b", 1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'h0, 1'b1,
                   32'h0, 1'b0, 1'b1);

    // Console "HI": no bypass, strobe[0]=0 does not push, level 2, in order.
    apply_stimulus("push_h", 1'b0, 1'b1, BASE + 32'h4, 32'h48, 4'h1, 1'b1,
                   32'h0, 1'b0, 1'b0);
    check_output("no_bypass", 64'(cons_valid), 64'd0);
    apply_stimulus("push_i", 1'b0, 1'b1, BASE + 32'h4, 32'h49, 4'h1, 1'b1,
                   32'h0, 1'b0, 1'b0);
    check_output("head_visible", 64'(cons_valid), 64'd1);
    check_output("head_byte", 64'(cons_data), 64'h48);
    apply_stimulus("push_nostrb", 1'b0, 1'b1, BASE + 32'h4, 32'h55, 4'hE,
                   1'b1, 32'h0, 1'b0, 1'b0);
    apply_stimulus("status_hi", 1'b1, 1'b0, BASE + 32'hC, 32'h0, 4'h0, 1'b1,
                   32'h0000_0201, 1'b0, 1'b0);
    idle();
    exp_bytes = '{8'h48, 8'h49};
    drain_console("hi");

    // Overflow: 17 pushes into 16 entries, clear by STATUS write.
    for (int i = 0; i < 17; i++) begin
      apply_stimulus("fill", 1'b0, 1'b1, BASE + 32'h4, 32'h10 + 32'(i), 4'h1,
                     1'b1, 32'h0, 1'b0, 1'b0);
    end
    apply_stimulus("status_ovf", 1'b1, 1'b0, BASE + 32'hC, 32'h0, 4'h0, 1'b1,
                   32'h0000_1003, 1'b0, 1'b0);
    apply_stimulus("clr_ovf", 1'b0, 1'b1, BASE + 32'hC, 32'h0, 4'hF, 1'b1,
                   32'h0, 1'b0, 1'b0);
    apply_stimulus("status_clr", 1'b1, 1'b0, BASE + 32'hC, 32'h0, 4'h0, 1'b1,
                   32'h0000_1001, 1'b0, 1'b0);

    // Full FIFO: push and pop together keep the level and raise no overflow.
    @(negedge clk);
    r_v        = 1'b0;
    w_v        = 1'b1;
    adr        = BASE + 32'h4;
    data       = 32'h77;
    strobe     = 4'h1;
    cons_ready = 1'b1;
    #1;
    check_output("pushpop_head", 64'(cons_data), 64'h10);
    exp_q.push_back('{32'h0, 1'b0});
    @(negedge clk);
    cons_ready = 1'b0;
    w_v        = 1'b0;
    apply_stimulus("status_pushpop", 1'b1, 1'b0, BASE + 32'hC, 32'h0, 4'h0,
                   1'b1, 32'h0000_1001, 1'b0, 1'b0);
    idle();
    exp_bytes.delete();
    for (int i = 1; i < 16; i++) exp_bytes.push_back(8'h10 + 8'(i));
    exp_bytes.push_back(8'h77);
    drain_console("ovf");

    // Reset mid-stream: in-flight request dropped, everything cleared.
    apply_stimulus("push_pre_rst", 1'b0, 1'b1, BASE + 32'h4, 32'h33, 4'h1,
                   1'b1, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    w_v = 1'b0;
    r_v = 1'b1;
    adr = BASE + 32'hC;
    @(negedge clk);
    check_output("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check_output("mid_rst_resp", 64'(resp), 64'd0);
    check_output("mid_rst_cons_valid", 64'(cons_valid), 64'd0);
    check_output("mid_rst_cons_data", 64'(cons_data), 64'd0);
    check_output("mid_rst_exit_valid", 64'(exit_valid), 64'd0);
    check_output("mid_rst_exit_status", 64'(exit_status), 64'd0);
    check_output("mid_rst_exit_timeout", 64'(exit_timeout), 64'd0);
    rst = 1'b0;
    r_v = 1'b0;
    apply_stimulus("status_post_rst", 1'b1, 1'b0, BASE + 32'hC, 32'h0, 4'h0,
                   1'b1, 32'h0, 1'b0, 1'b0);
    apply_stimulus("cycle_post_rst", 1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'h0,
                   1'b1, 32'h0, 1'b0, 1'b1);
    idle();

    // Watchdog: exit appears exactly after the 101st edge out of reset.
    @(negedge clk);
    wd_rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check_output("wd_before", 64'(wd_exit_valid), 64'd0);
    @(posedge clk);
    #1;
    check_output("wd_exit_valid", 64'(wd_exit_valid), 64'd1);
    check_output("wd_exit_timeout", 64'(wd_exit_timeout), 64'd1);
    check_output("wd_exit_status", 64'(wd_exit_status), 64'hFFFF_FFFF);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
